// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by an internal SRAM array; fixed-latency, one request outstanding.
// Optional back-pressure model: define DBUS_RESP_RANDOM_STALL_EN.
package dbus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          LATENCY    = 2,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   req,
  output dbus_resp_t  resp,
  output logic [31:0] req_cnt
);

  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CW-1:0]           r_lat;
  logic [31:0]             r_req_cnt;
  logic [31:0]             r_rdata;
  logic [31:0]             r_last;
  logic [31:0]             r_mem [0:(2**ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [31:0]             w_word;
  logic                    w_stall_ok;
  logic                    w_addr_ok;
  logic                    w_unused;

  assign w_idx = req.addr[ADDR_WIDTH+1:2];

`ifdef DBUS_RESP_RANDOM_STALL_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= STALL_SEED;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_stall_ok = r_lfsr[0];
  assign w_unused   = ^{req.size, req.addr[31:ADDR_WIDTH+2], req.addr[1:0]};
`else
  assign w_stall_ok = 1'b1;
  assign w_unused   = ^{req.size, req.addr[31:ADDR_WIDTH+2], req.addr[1:0], STALL_SEED};
`endif

  // addr_ok is held low during reset even though the state register already reads IDLE
  assign w_addr_ok = (r_state == IDLE) & req.valid & w_stall_ok & ~reset;

  always_comb begin
    w_word = r_mem[w_idx];
    for (int unsigned i = 0; i < 4; i++) begin
      if (req.strobe[i]) w_word[8*i +: 8] = req.data[8*i +: 8];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_addr_ok) w_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (r_lat == CW'(1)) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_lat     <= '0;
      r_req_cnt <= '0;
      r_rdata   <= '0;
      r_last    <= '0;
    end else begin
      r_state <= w_next;
      if (w_addr_ok) begin
        r_lat     <= CW'(LATENCY - 1);
        r_req_cnt <= r_req_cnt + 32'd1;
        r_rdata   <= w_word;
      end else if (r_state == WAIT) begin
        r_lat <= r_lat - 1'b1;
      end
      if (r_state == RESP) r_last <= r_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_addr_ok) r_mem[w_idx] <= w_word;
  end

  // Data bus shows the fresh response only in RESP, otherwise the previous one
  always_comb begin
    resp.addr_ok = w_addr_ok;
    resp.data_ok = (r_state == RESP);
    resp.data    = (r_state == RESP) ? r_rdata : r_last;
  end

  assign req_cnt = r_req_cnt;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed self-checking bench for dbus_sram_responder (ADDR_WIDTH=10, LATENCY=2).
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  dbus_req_t   req;
  dbus_resp_t  resp;
  logic [31:0] req_cnt;

  int          vectors;
  int          miscompares;
  logic [31:0] exp_cnt;

  dbus_sram_responder #(.ADDR_WIDTH(10), .LATENCY(LAT), .STALL_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .req(req), .resp(resp), .req_cnt(req_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction: issues the request, returns wait cycles before addr_ok,
  // cycles from accept to data_ok, response data, and data_ok in the following cycle.
  task automatic xact(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      output int waitc, output int lat, output logic [31:0] rd,
                      output logic ok_after);
    @(negedge clk);
    req.valid = 1'b1; req.addr = a; req.strobe = s; req.data = d; req.size = 2'd2;
    #1;
    waitc = 0;
    while (!resp.addr_ok && waitc < 40) begin
      @(negedge clk); #1; waitc++;
    end
    @(posedge clk); #1;
    req.valid = 1'b0; req.data = 32'hFFFF_FFFF; req.strobe = 4'hF;
    lat = 0; rd = 'x;
    while (lat < 20) begin
      @(negedge clk); lat++;
      if (resp.data_ok) begin rd = resp.data; break; end
    end
    @(negedge clk);
    ok_after = resp.data_ok;
    exp_cnt++;
  endtask

  task automatic test_reset;
    vectors++;
    if (resp.addr_ok !== 1'b0) begin miscompares++; $display("FAIL reset_addr_ok got %b want 0", resp.addr_ok); end
    vectors++;
    if (resp.data_ok !== 1'b0) begin miscompares++; $display("FAIL reset_data_ok got %b want 0", resp.data_ok); end
    vectors++;
    if (resp.data !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", resp.data); end
    vectors++;
    if (req_cnt !== 32'h0) begin miscompares++; $display("FAIL reset_req_cnt got %0d want 0", req_cnt); end
  endtask

  task automatic test_write;
    int w, l; logic [31:0] rd; logic oa;
    xact(32'h10, 4'hF, 32'hDEADBEEF, w, l, rd, oa);
`ifndef DBUS_RESP_RANDOM_STALL_EN
    vectors++;
    if (w !== 0) begin miscompares++; $display("FAIL write_addr_ok_wait got %0d want 0", w); end
`endif
    vectors++;
    if (l !== LAT) begin miscompares++; $display("FAIL write_latency got %0d want %0d", l, LAT); end
    vectors++;
    if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL write_data got %h want deadbeef", rd); end
    vectors++;
    if (oa !== 1'b0) begin miscompares++; $display("FAIL write_data_ok_one_cycle got %b want 0", oa); end
    vectors++;
    if (req_cnt !== 32'd1) begin miscompares++; $display("FAIL write_req_cnt got %0d want 1", req_cnt); end
  endtask

  task automatic test_read;
    int w, l; logic [31:0] rd; logic oa;
    xact(32'h10, 4'h0, 32'h1234_5678, w, l, rd, oa);
    vectors++;
    if (l !== LAT) begin miscompares++; $display("FAIL read_latency got %0d want %0d", l, LAT); end
    vectors++;
    if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL read_data got %h want deadbeef", rd); end
    vectors++;
    if (resp.data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL read_data_hold got %h want deadbeef", resp.data); end
  endtask

  task automatic test_partial;
    int w, l; logic [31:0] rd; logic oa;
    xact(32'h10, 4'b0010, 32'h0000AA00, w, l, rd, oa);
    vectors++;
    if (rd !== 32'hDEADAAEF) begin miscompares++; $display("FAIL partial_byte1 got %h want deadaaef", rd); end
    xact(32'h10, 4'b1000, 32'h11000000, w, l, rd, oa);
    vectors++;
    if (rd !== 32'h11ADAAEF) begin miscompares++; $display("FAIL partial_byte3 got %h want 11adaaef", rd); end
    xact(32'h10, 4'h0, 32'h0, w, l, rd, oa);
    vectors++;
    if (rd !== 32'h11ADAAEF) begin miscompares++; $display("FAIL partial_readback got %h want 11adaaef", rd); end
  endtask

  task automatic test_alias;
    int w, l; logic [31:0] rd; logic oa;
    xact(32'h1000, 4'hF, 32'h55, w, l, rd, oa);
    xact(32'h0, 4'h0, 32'h0, w, l, rd, oa);
    vectors++;
    if (rd !== 32'h55) begin miscompares++; $display("FAIL alias_upper got %h want 00000055", rd); end
    xact(32'h3, 4'h0, 32'h0, w, l, rd, oa);
    vectors++;
    if (rd !== 32'h55) begin miscompares++; $display("FAIL alias_lowbits got %h want 00000055", rd); end
  endtask

  task automatic test_back_to_back;
    int acc, cyc, last, n;
    logic seen;
    logic [31:0] cnt0;
    cnt0 = req_cnt;
    @(negedge clk);
    req.valid = 1'b1; req.addr = 32'h10; req.strobe = 4'h0; req.data = 32'h0;
    acc = 0; cyc = 0; last = -1;
    while (acc < 3 && cyc < 60) begin
      #1;
      vectors++;
      if (resp.addr_ok && resp.data_ok) begin
        miscompares++; $display("FAIL b2b_overlap cycle %0d addr_ok=1 data_ok=1 want not both", cyc);
      end
      if (resp.addr_ok) begin
        acc++;
`ifndef DBUS_RESP_RANDOM_STALL_EN
        if (last >= 0) begin
          vectors++;
          if (cyc - last !== LAT + 1) begin
            miscompares++; $display("FAIL b2b_spacing got %0d want %0d", cyc - last, LAT + 1);
          end
        end
`endif
        last = cyc;
      end
      if (acc == 3) begin
        @(posedge clk); #1; req.valid = 1'b0;
      end else begin
        @(negedge clk); cyc++;
      end
    end
    vectors++;
    if (acc !== 3) begin miscompares++; $display("FAIL b2b_accepts got %0d want 3", acc); end
    n = 0; seen = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk); n++;
      seen = resp.data_ok;
    end
    vectors++;
    if (seen !== 1'b1) begin miscompares++; $display("FAIL b2b_final_data_ok got %b want 1", seen); end
    exp_cnt = exp_cnt + 3;
    vectors++;
    if (req_cnt !== cnt0 + 32'd3) begin miscompares++; $display("FAIL b2b_req_cnt got %0d want %0d", req_cnt, cnt0 + 32'd3); end
  endtask

  task automatic test_reset_mid;
    int w, l, n; logic [31:0] rd; logic oa, fired;
    @(negedge clk);
    req.valid = 1'b1; req.addr = 32'h40; req.strobe = 4'hF; req.data = 32'h12345678;
    #1;
    n = 0;
    while (!resp.addr_ok && n < 40) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    req.valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (resp.addr_ok !== 1'b0) begin miscompares++; $display("FAIL rstmid_addr_ok got %b want 0", resp.addr_ok); end
    vectors++;
    if (req_cnt !== 32'd0) begin miscompares++; $display("FAIL rstmid_req_cnt got %0d want 0", req_cnt); end
    @(posedge clk); #1;
    reset = 1'b0;
    fired = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp.data_ok) fired = 1'b1;
    end
    vectors++;
    if (fired !== 1'b0) begin miscompares++; $display("FAIL rstmid_data_ok got %b want 0", fired); end
    exp_cnt = 0;
    xact(32'h40, 4'h0, 32'h0, w, l, rd, oa);
    vectors++;
    if (rd !== 32'h12345678) begin miscompares++; $display("FAIL rstmid_write_kept got %h want 12345678", rd); end
    vectors++;
    if (req_cnt !== exp_cnt) begin miscompares++; $display("FAIL rstmid_cnt_after got %0d want %0d", req_cnt, exp_cnt); end
  endtask

  initial begin
    vectors = 0; miscompares = 0; exp_cnt = 0;
    reset = 1'b1;
    req = '0;
    req.valid = 1'b1;
    #12;
    test_reset;
    @(negedge clk);
    req.valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    test_write;
    test_read;
    test_partial;
    test_alias;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at %0t want completion", $time);
    $fatal(1, "timeout");
  end

endmodule
